// File: rtl/mem_pkg.sv
// Shared types and constants for the dual-core data-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } port_state_t;

    localparam int          WORD_W    = 32;
    localparam int          CNT_W     = 16;
    localparam logic [31:0] OOR_RDATA = 32'h0;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the winner of a tie is the port named by prio.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] elig,
    output logic [1:0] gnt,
    output logic       both
);

    logic prio;

    always_comb begin
        both = &elig;
        gnt  = elig;
        if (both) begin
            gnt       = 2'b00;
            gnt[prio] = 1'b1;
        end
    end

    // Priority flips to the other port after every grant, contended or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/dual_dmem_responder.sv
// Single-ported word array shared by two cores through a req/ack handshake
// with round-robin arbitration and a registered read path.
module dual_dmem_responder
    import mem_pkg::*;
#(
    parameter int AW        = 10,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [CNT_W-1:0]  conflict_cnt
);

    logic [WORD_W-1:0] mem [0:(1<<AW)-1];

    port_state_t       state_q [2];
    port_state_t       state_d [2];
    logic [1:0]        req;
    logic [1:0]        ack;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              both;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              in_range;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] rdata0_q;
    logic [WORD_W-1:0] rdata1_q;
    logic [CNT_W-1:0]  conflict_q;
    logic              unused_bits;

    assign req  = {req1, req0};
    // A port in its ack cycle is not eligible, so a still-held req is not re-granted.
    assign elig = req & ~ack;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .elig  (elig),
        .gnt   (gnt),
        .both  (both)
    );

    assign acc_we      = gnt[1] ? we1    : we0;
    assign acc_addr    = gnt[1] ? addr1  : addr0;
    assign acc_wdata   = gnt[1] ? wdata1 : wdata0;
    assign in_range    = (acc_addr[31:AW+2] == '0);
    assign idx         = acc_addr[AW+1:2];
    assign unused_bits = ^acc_addr[1:0];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                state_q[i] <= IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Dropping req while waiting abandons the access without touching memory.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE:    if (req[i]) state_d[i] = gnt[i] ? ACK : WAIT;
                WAIT:    if (gnt[i]) state_d[i] = ACK;
                         else if (!req[i]) state_d[i] = IDLE;
                ACK:     state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ack[i] = (state_q[i] == ACK);
        end
    end

    // A store granted on the same edge as reset is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && (|gnt) && acc_we && in_range) begin
            mem[idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (gnt[0] && !we0) rdata0_q <= in_range ? mem[idx] : OOR_RDATA;
            if (gnt[1] && !we1) rdata1_q <= in_range ? mem[idx] : OOR_RDATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= '0;
        end else if (both && (conflict_q != {CNT_W{1'b1}})) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign ack0         = ack[0];
    assign ack1         = ack[1];
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dual_dmem_responder.sv
// Scoreboard bench: drivers queue the expected completion, a negedge monitor checks each ack.
module tb_dual_dmem_responder;

    typedef struct {
        int          issue_cyc;
        int          lat;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [15:0] conflict_cnt;

    int   cyc;
    int   n_cmp;
    int   n_err;
    bit   exp_prio;
    exp_t q0[$];
    exp_t q1[$];

    dual_dmem_responder #(.AW(10), .INIT_FILE("")) dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .conflict_cnt (conflict_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ack(input int port, input logic [31:0] rd);
        exp_t e;
        if (port == 0 && q0.size() == 0 || port == 1 && q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL spurious_ack%0d: got ack, expected none (cycle %0d)", port, cyc);
        end else begin
            e = (port == 0) ? q0.pop_front() : q1.pop_front();
            check_output($sformatf("latency%0d", port), cyc - e.issue_cyc, e.lat);
            check_output($sformatf("rdata%0d", port), rd, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (ack0) check_ack(0, rdata0);
        if (ack1) check_ack(1, rdata1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        exp_prio = 1'b0;
    endtask

    // exp_data is the load result, or for a store the value rdata must still hold.
    task automatic apply_stimulus(input int port, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_data,
                                  input int exp_lat);
        exp_t e;
        bit   got;
        e.issue_cyc = cyc;
        e.lat       = exp_lat;
        e.data      = exp_data;
        got         = 1'b0;
        if (port == 0) begin
            q0.push_back(e);
            we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
        end else begin
            q1.push_back(e);
            we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if ((port == 0) ? ack0 : ack1) begin
                got = 1'b1;
                break;
            end
        end
        if (port == 0) req0 = 1'b0; else req1 = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL ack_timeout%0d: got no ack, expected ack within 10 cycles", port);
        end
        step();
    endtask

    // One contended cycle: both load word 0, winner predicted from the bench's prio model.
    task automatic contend(input logic [15:0] exp_cnt);
        exp_t e;
        e.issue_cyc = cyc;
        e.lat       = 1;
        e.data      = 32'hCAFE0000;
        if (exp_prio == 1'b0) q0.push_back(e); else q1.push_back(e);
        exp_prio = ~exp_prio;
        we0 = 1'b0; we1 = 1'b0; addr0 = 32'h0; addr1 = 32'h0;
        req0 = 1'b1; req1 = 1'b1;
        step();
        check_output("conflict_sat", {16'h0, conflict_cnt}, {16'h0, exp_cnt});
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_err = 0; exp_prio = 1'b0;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        step();
        apply_reset();

        check_output("reset_ack0", {31'h0, ack0}, 32'h0);
        check_output("reset_ack1", {31'h0, ack1}, 32'h0);
        check_output("reset_rdata0", rdata0, 32'h0);
        check_output("reset_rdata1", rdata1, 32'h0);
        check_output("reset_cnt", {16'h0, conflict_cnt}, 32'h0);

        // Basic store then load on port 0.
        apply_stimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1);
        apply_stimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
        check_output("basic_cnt", {16'h0, conflict_cnt}, 32'h0);

        // Contention from reset: port 0 first, then port 1; repeat to see prio wrap.
        apply_reset();
        fork
            apply_stimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
            apply_stimulus(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2);
        join
        check_output("contend_cnt1", {16'h0, conflict_cnt}, 32'd1);
        fork
            apply_stimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
            apply_stimulus(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2);
        join
        check_output("contend_cnt2", {16'h0, conflict_cnt}, 32'd2);

        // Seed word 0 and leave prio at 1, then same-word store/load race.
        apply_stimulus(0, 1'b1, 32'h0, 32'hCAFE0000, 32'hDEADBEEF, 1);
        fork
            apply_stimulus(1, 1'b1, 32'h20, 32'h5, 32'hDEADBEEF, 1);
            apply_stimulus(0, 1'b0, 32'h20, 32'h0, 32'h5, 2);
        join
        check_output("order_cnt", {16'h0, conflict_cnt}, 32'd3);

        // Out-of-range store aliases word 0 if the range check is missing.
        apply_stimulus(0, 1'b1, 32'h0000_1000, 32'h12345678, 32'h5, 1);
        apply_stimulus(0, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1);
        apply_stimulus(0, 1'b0, 32'h0, 32'h0, 32'hCAFE0000, 1);

        // Reset on the grant edge of a store.
        we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'hBADBAD00; req0 = 1'b1;
        reset = 1'b1;
        step();
        req0 = 1'b0; reset = 1'b0;
        exp_prio = 1'b0;
        check_output("midrst_ack0", {31'h0, ack0}, 32'h0);
        check_output("midrst_ack1", {31'h0, ack1}, 32'h0);
        check_output("midrst_rdata0", rdata0, 32'h0);
        check_output("midrst_rdata1", rdata1, 32'h0);
        check_output("midrst_cnt", {16'h0, conflict_cnt}, 32'h0);
        step();
        step();
        apply_stimulus(0, 1'b0, 32'h0, 32'h0, 32'hCAFE0000, 1);

        // Saturation: preload the counter near the top, then contend past it.
        apply_reset();
        force dut.conflict_q = 16'hFFFD;
        #1;
        release dut.conflict_q;
        contend(16'hFFFE);
        contend(16'hFFFF);
        contend(16'hFFFF);
        contend(16'hFFFF);

        repeat (3) step();
        check_output("q0_drained", q0.size(), 32'd0);
        check_output("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
